su_mul8_seq: RTL and testbench

- Multi-cycle 8x8 signed×unsigned multiplier built around one shared 4x4 signed×unsigned multiplier core (s[3:0] signed, u[3:0] unsigned, out[7:0] signed product).
- The core is instantiated internally and time-multiplexed over four nibble partial products, under valid/ready control.
- Intended for area-constrained paths in the exact-multiplier library where a full 8x8 array is not affordable.

---
 rtl/su_mul8_seq.sv | 154 +++++++++++++++
 tb/tb_su_mul8_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/su_mul8_seq.sv
// su_mul8_seq: multi-cycle 8x8 multiplier, signed multiplicand times unsigned
// multiplier. One shared 4x4 signed x unsigned core is reused over four nibble
// partial products, which are summed in a 16-bit accumulator.
//
// Parameters:
//   PIPE_CORE  1 = register the core output before accumulating (2 cycles/step)
//   ZERO_SKIP  1 = a zero operand skips the steps and returns 0 immediately
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; in_a signed, in_b unsigned (8 bit)
//   out_valid/out_ready  result handshake; out_p signed 16-bit product
//   busy                 high whenever the FSM is not in IDLE

module su_mul4_core (
  input  logic [3:0] s_i,   // signed nibble
  input  logic [3:0] u_i,   // unsigned nibble
  output logic [7:0] p_o    // signed product
);
  logic signed [8:0] s_ext, u_ext, prod;

  always_comb begin
    s_ext = {{5{s_i[3]}}, s_i};
    u_ext = {5'b0, u_i};
    prod  = s_ext * u_ext;
    p_o   = prod[7:0];
  end
endmodule

module su_mul8_seq #(
  parameter bit PIPE_CORE = 1'b0,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] p_q, p_d;
  logic [1:0]  step_q, step_d;
  logic        ph_q, ph_d;      // PIPE_CORE phase: 0 = present, 1 = accumulate
  logic [7:0]  core_q, core_d;

  logic [3:0]  core_s, core_u;
  logic [7:0]  core_p, core_src;
  logic [15:0] prod16, term;

  // step0 Al*Bl, step1 Al*Bh, step2 Ah*Bl, step3 Ah*Bh
  assign core_s = step_q[1] ? a_q[7:4] : a_q[3:0];
  assign core_u = step_q[0] ? b_q[7:4] : b_q[3:0];

  su_mul4_core u_core (
    .s_i(core_s),
    .u_i(core_u),
    .p_o(core_p)
  );

  assign core_src = PIPE_CORE ? core_q : core_p;

  always_comb begin
    // The core reads Al as signed; when Al[3] is set the true unsigned value
    // is 16 larger, so add Bn<<4 back for the two Al steps.
    prod16 = {{8{core_src[7]}}, core_src}
           + ((!step_q[1] && a_q[3]) ? {8'b0, core_u, 4'b0} : 16'd0);
    case (step_q)
      2'd0:    term = prod16;
      2'd3:    term = prod16 << 8;
      default: term = prod16 << 4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    step_d  = step_q;
    ph_d    = ph_q;
    core_d  = core_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d    = in_a;
          b_d    = in_b;
          acc_d  = 16'd0;
          step_d = 2'd0;
          ph_d   = 1'b0;
          if (ZERO_SKIP && (in_a == 8'd0 || in_b == 8'd0)) begin
            state_d = DONE;
            p_d     = 16'd0;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        if (PIPE_CORE && !ph_q) begin
          core_d = core_p;
          ph_d   = 1'b1;
        end else begin
          acc_d  = acc_q + term;
          ph_d   = 1'b0;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_d = DONE;
            p_d     = acc_q + term;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= 16'd0;
      p_q     <= 16'd0;
      step_q  <= 2'd0;
      ph_q    <= 1'b0;
      core_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      step_q  <= step_d;
      ph_q    <= ph_d;
      core_q  <= core_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = p_q;
endmodule

// File: tb/tb_su_mul8_seq.sv
module tb_su_mul8_seq;
  // Instance 0: PIPE_CORE=0 ZERO_SKIP=1; 1: PIPE_CORE=1 ZERO_SKIP=1;
  // 2: PIPE_CORE=0 ZERO_SKIP=0
  localparam int N = 3;

  logic        clk, rst;
  logic        iv [N], ir [N], ov [N], ordy [N], bz [N];
  logic [7:0]  ia [N], ib [N];
  logic [15:0] op [N];

  int tests = 0, fails = 0, cyc = 0;
  logic [15:0] sbq [$];
  int          accq [$], latq [$];

  for (genvar g = 0; g < N; g++) begin : g_dut
    su_mul8_seq #(.PIPE_CORE(g == 1), .ZERO_SKIP(g != 2)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(iv[g]), .in_ready(ir[g]), .in_a(ia[g]), .in_b(ib[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]), .out_p(op[g]), .busy(bz[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] a; logic [7:0] b; logic [15:0] p; } vec_t;

  function automatic logic [15:0] mref(logic [7:0] a, logic [7:0] b);
    int sa, p;
    sa = int'($signed(a));
    p  = sa * int'(b);
    return p[15:0];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One operation on instance k with out_ready high; checks busy, latency
  // (edges after the accept edge until out_valid) and the product.
  task automatic run_op(int k, logic [7:0] a, logic [7:0] b, logic [15:0] exp,
                        int elat, string nm);
    int n, lat;
    @(negedge clk);
    ia[k] = a; ib[k] = b; iv[k] = 1'b1; ordy[k] = 1'b1;
    n = 0;
    while (!ir[k] && n < 50) begin @(negedge clk); n++; end
    chk({nm, "_ready"}, ir[k], 1);
    sbq.push_back(exp);
    @(negedge clk);
    iv[k] = 1'b0; ia[k] = ~a; ib[k] = ~b;
    chk({nm, "_busy"}, bz[k], 1);
    lat = 0;
    while (!ov[k] && lat < 20) begin @(negedge clk); lat++; end
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_p"}, op[k], sbq.pop_front());
  endtask

  vec_t vecs [10];

  initial begin
    int n;
    vecs = '{
      '{8'h7F, 8'hFF, 16'h7E81}, '{8'h80, 8'hFF, 16'h8080},
      '{8'hF9, 8'h0B, 16'hFFB3}, '{8'h12, 8'h34, 16'h03A8},
      '{8'h03, 8'h05, 16'h000F}, '{8'hFF, 8'hFF, 16'hFF01},
      '{8'h80, 8'h01, 16'hFF80}, '{8'h01, 8'h80, 16'h0080},
      '{8'h7F, 8'h01, 16'h007F}, '{8'h88, 8'h88, 16'hC040}};

    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; ia[k] = 8'h0; ib[k] = 8'h0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_ready%0d", k), ir[k], 1);
      chk($sformatf("rst_valid%0d", k), ov[k], 0);
      chk($sformatf("rst_p%0d", k), op[k], 0);
      chk($sformatf("rst_busy%0d", k), bz[k], 0);
    end

    // table vectors on every instance
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 10; i++)
        run_op(k, vecs[i].a, vecs[i].b, vecs[i].p, (k == 1) ? 8 : 4,
               $sformatf("vec%0d_%0d", k, i));

    // zero operands: skipped vs full multiply
    run_op(0, 8'h00, 8'h5A, 16'h0000, 0, "zskip_a");
    run_op(0, 8'h5A, 8'h00, 16'h0000, 0, "zskip_b");
    run_op(2, 8'h00, 8'h5A, 16'h0000, 4, "noskip_a");

    // backpressure: hold result in DONE for 10 cycles
    @(negedge clk);
    ia[0] = 8'h12; ib[0] = 8'h34; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", ov[0], 1);
      chk("hold_p", op[0], 16'h03A8);
      chk("hold_ready", ir[0], 0);
      iv[0] = i[0]; ia[0] = 8'($urandom); ib[0] = 8'($urandom);
      @(negedge clk);
    end
    iv[0] = 1'b1; ia[0] = 8'h03; ib[0] = 8'h05; ordy[0] = 1'b1;
    @(negedge clk);
    chk("retire_valid", ov[0], 0);
    chk("retire_ready", ir[0], 1);
    chk("retire_p_held", op[0], 16'h03A8);
    @(negedge clk);
    iv[0] = 1'b0;
    chk("next_busy", bz[0], 1);
    n = 0;
    while (!ov[0] && n < 20) begin @(negedge clk); n++; end
    chk("next_lat", n, 4);
    chk("next_p", op[0], 16'h000F);

    // reset during step2
    @(negedge clk);
    ia[0] = 8'h55; ib[0] = 8'hAA; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", bz[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", ov[0], 0);
    chk("mid_rst_p", op[0], 0);
    chk("mid_rst_ready", ir[0], 1);
    chk("mid_rst_busy", bz[0], 0);
    run_op(0, 8'h03, 8'h05, 16'h000F, 4, "after_rst");

    // random pairs with backpressure on the pipelined instance
    sbq.delete();
    fork
      begin : drv
        int sent, g;
        bit taken;
        sent = 0; g = 0; taken = 1'b0;
        iv[1] = 1'b0;
        while (sent < 1000 && g < 60000) begin
          @(negedge clk); g++;
          if (taken) begin iv[1] = 1'b0; taken = 1'b0; end
          if (!iv[1] && $urandom_range(3) != 0) begin
            iv[1] = 1'b1; ia[1] = 8'($urandom); ib[1] = 8'($urandom);
          end
          if (iv[1] && ir[1]) begin
            sbq.push_back(mref(ia[1], ib[1]));
            accq.push_back(cyc + 1);
            latq.push_back((ia[1] == 8'h0 || ib[1] == 8'h0) ? 0 : 8);
            sent++; taken = 1'b1;
          end
        end
        @(negedge clk);
        iv[1] = 1'b0;
      end
      begin : mon
        int got, g;
        bit seen;
        got = 0; g = 0; seen = 1'b0;
        while (got < 1000 && g < 60000) begin
          @(negedge clk); g++;
          ordy[1] = ($urandom_range(2) != 0);
          if (ov[1] && !seen) begin
            seen = 1'b1;
            if (sbq.size() == 0) chk("rnd_unexpected", 1, 0);
            else begin
              chk("rnd_p", op[1], sbq.pop_front());
              chk("rnd_lat", cyc - accq.pop_front(), latq.pop_front());
            end
          end
          if (ov[1] && ordy[1]) begin seen = 1'b0; got++; end
        end
        chk("rnd_count", got, 1000);
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
